// File: rtl/nanov_spi_instr_fetch.sv
// SPI-flash instruction fetch: streams 32-bit words with the READ command and hands them
// to the core through a one-word valid/ready buffer; start restarts the stream at a new address.
module nanov_spi_instr_fetch #(
  parameter int unsigned ADDR_BITS  = 24,
  parameter logic [7:0]  READ_CMD   = 8'h03,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [ADDR_BITS-1:0] start_addr_i,
  input  logic                 instr_ready_i,
  output logic                 instr_valid_o,
  output logic [31:0]          instr_o,
  output logic [ADDR_BITS-1:0] instr_addr_o,
  output logic                 spi_cs_n_o,
  output logic                 spi_sck_o,
  output logic                 spi_mosi_o,
  input  logic                 spi_miso_i,
  output logic [2:0]           dbg_state_o
);

  // Handshake: a word transfers on any cycle with instr_valid_o && instr_ready_i; instr_o and
  // instr_addr_o hold steady while valid is high and ready is low.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GAP   = 3'd1,
    S_CMD   = 3'd2,
    S_ADDR  = 3'd3,
    S_DATA  = 3'd4,
    S_STALL = 3'd5
  } state_e;

  localparam int CW = (ADDR_BITS > 32) ? $clog2(ADDR_BITS) : 5;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int TW = 8 + ADDR_BITS;

  state_e               state_q, state_d;
  logic                 phase_q, phase_d;
  logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [TW-1:0]        tx_q, tx_d;
  logic [31:0]          rx_q, rx_d;
  logic [ADDR_BITS-1:0] fetch_addr_q, fetch_addr_d;
  logic [31:0]          instr_q, instr_d;
  logic [ADDR_BITS-1:0] instr_addr_q, instr_addr_d;
  logic                 valid_q, valid_d;
  logic                 cs_n_q, cs_n_d;
  logic                 sck_q, sck_d;
  logic                 mosi_q, mosi_d;
  logic [31:0]          rx_word;

  // Serial stream arrives byte0 first; the core wants byte0 in the low lane.
  function automatic logic [31:0] swap_bytes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  always_comb begin
    state_d      = state_q;
    phase_d      = phase_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    fetch_addr_d = fetch_addr_q;
    instr_d      = instr_q;
    instr_addr_d = instr_addr_q;
    valid_d      = valid_q;
    rx_word      = {rx_q[30:0], spi_miso_i};

    if (valid_q && instr_ready_i) valid_d = 1'b0;

    if (start_i) begin
      state_d      = S_GAP;
      phase_d      = 1'b0;
      gap_cnt_d    = GW'(GAP_CYCLES - 1);
      fetch_addr_d = start_addr_i & ~ADDR_BITS'(3);
      tx_d         = {READ_CMD, start_addr_i & ~ADDR_BITS'(3)};
      valid_d      = 1'b0;
    end else begin
      case (state_q)
        S_GAP: begin
          if (gap_cnt_q == '0) begin
            state_d   = S_CMD;
            phase_d   = 1'b0;
            bit_cnt_d = CW'(7);
          end else begin
            gap_cnt_d = gap_cnt_q - 1'b1;
          end
        end
        S_CMD, S_ADDR, S_DATA: begin
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            tx_d    = tx_q << 1;
            if (state_q == S_DATA) rx_d = rx_word;
            if (bit_cnt_q != '0) begin
              bit_cnt_d = bit_cnt_q - 1'b1;
            end else if (state_q == S_CMD) begin
              state_d   = S_ADDR;
              bit_cnt_d = CW'(ADDR_BITS - 1);
            end else if (state_q == S_ADDR) begin
              state_d   = S_DATA;
              bit_cnt_d = CW'(31);
            end else begin
              bit_cnt_d = CW'(31);
              if (!valid_q || instr_ready_i) begin
                instr_d      = swap_bytes(rx_word);
                instr_addr_d = fetch_addr_q;
                fetch_addr_d = fetch_addr_q + ADDR_BITS'(4);
                valid_d      = 1'b1;
              end else begin
                state_d = S_STALL;
              end
            end
          end
        end
        S_STALL: begin
          if (instr_ready_i) begin
            instr_d      = swap_bytes(rx_q);
            instr_addr_d = fetch_addr_q;
            fetch_addr_d = fetch_addr_q + ADDR_BITS'(4);
            valid_d      = 1'b1;
            state_d      = S_DATA;
            phase_d      = 1'b0;
            bit_cnt_d    = CW'(31);
          end
        end
        default: ;
      endcase
    end

    // Pins are registered from the next state so they change cleanly on the clock edge.
    cs_n_d = (state_d == S_IDLE) || (state_d == S_GAP);
    sck_d  = phase_d && ((state_d == S_CMD) || (state_d == S_ADDR) || (state_d == S_DATA));
    mosi_d = ((state_d == S_CMD) || (state_d == S_ADDR)) && tx_d[TW-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      phase_q      <= 1'b0;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      tx_q         <= '0;
      rx_q         <= '0;
      fetch_addr_q <= '0;
      instr_q      <= '0;
      instr_addr_q <= '0;
      valid_q      <= 1'b0;
      cs_n_q       <= 1'b1;
      sck_q        <= 1'b0;
      mosi_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      fetch_addr_q <= fetch_addr_d;
      instr_q      <= instr_d;
      instr_addr_q <= instr_addr_d;
      valid_q      <= valid_d;
      cs_n_q       <= cs_n_d;
      sck_q        <= sck_d;
      mosi_q       <= mosi_d;
    end
  end

  assign instr_valid_o = valid_q;
  assign instr_o       = instr_q;
  assign instr_addr_o  = instr_addr_q;
  assign spi_cs_n_o    = cs_n_q;
  assign spi_sck_o     = sck_q;
  assign spi_mosi_o    = mosi_q;
  assign dbg_state_o   = state_q;

endmodule
